// File: rtl/mem_port_ctrl.sv
// Single-port word memory behind a CPU request/response handshake.
// Fixed-latency reads and writes with an explicit release phase before the next request.
module mem_port_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_oe,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy,
  output logic                 req_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 err_seen_q, err_seen_d;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic both_req;
  assign both_req = readM & writeM;

  generate
    if (WORD_SIZE > AW) begin : g_addr_hi
      // Upper address bits alias onto the low-order index by design.
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[WORD_SIZE-1:AW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_seen_q <= err_seen_d;
    end
  end

  // Memory is never cleared; a write that reset interrupts before WR_RESP is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == WR_RESP)
      mem[addr_q] <= wdata_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_seen_d = err_seen_q;
    case (state_q)
      IDLE: begin
        err_seen_d = both_req;
        if (readM && !writeM) begin
          addr_d  = address[AW-1:0];
          cnt_d   = CNT_LOAD;
          state_d = RD_WAIT;
        end else if (writeM && !readM) begin
          addr_d  = address[AW-1:0];
          wdata_d = data_in;
          cnt_d   = CNT_LOAD;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = RD_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) state_d = WR_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_RESP: state_d = RELEASE;
      WR_RESP: state_d = RELEASE;
      RELEASE: if (!readM && !writeM) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even before the state register clears.
  always_comb begin
    data_out   = '0;
    data_oe    = 1'b0;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    busy       = 1'b0;
    req_err    = 1'b0;
    if (!reset) begin
      busy    = (state_q != IDLE);
      req_err = (state_q == IDLE) && both_req && !err_seen_q;
      if (state_q == RD_RESP) begin
        data_out   = mem[addr_q];
        data_oe    = 1'b1;
        inputReady = 1'b1;
      end
      ackOutput = (state_q == WR_RESP);
    end
  end
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized self-checking bench for mem_port_ctrl against an array model of the memory.
module tb_mem_port_ctrl;
  localparam int W = 16;
  localparam int DEPTH = 256;
  localparam int LAT = 2;

  logic clk = 0, reset = 0, readM = 0, writeM = 0;
  logic [W-1:0] address = '0, data_in = '0;
  logic [W-1:0] data_out;
  logic data_oe, inputReady, ackOutput, busy, req_err;

  int tests = 0, fails = 0;
  logic [W-1:0] model [DEPTH];
  bit known [DEPTH];

  mem_port_ctrl #(.WORD_SIZE(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .readM(readM), .writeM(writeM),
    .address(address), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .inputReady(inputReady), .ackOutput(ackOutput),
    .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Runs one transaction from IDLE; reports response cycle (-1 if none), read data, oe at
  // the response, and whether outputs stayed quiet (busy high) in every waiting cycle.
  task automatic xact(input bit wr, input logic [W-1:0] a, input logic [W-1:0] d,
                      input bit drop_mid, output int lat, output logic [W-1:0] rd,
                      output logic oe, output bit quiet_ok);
    int cyc = 0;
    lat = -1; rd = '0; oe = 0; quiet_ok = 1;
    @(posedge clk); #1;
    readM = !wr; writeM = wr; address = a; data_in = d;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (drop_mid && cyc == 0) begin
        readM = 0; writeM = 0;
        address = W'($urandom); data_in = W'($urandom);
      end
      if (wr ? ackOutput : inputReady) begin
        lat = cyc; rd = data_out; oe = data_oe;
        break;
      end
      if (data_oe !== 1'b0 || data_out !== '0 || busy !== 1'b1 ||
          inputReady !== 1'b0 || ackOutput !== 1'b0) quiet_ok = 0;
      if (cyc >= LAT + 4) break;
      @(posedge clk); cyc++;
    end
    @(posedge clk); #1;
    readM = 0; writeM = 0;
    @(posedge clk);
    if (wr && lat >= 0) begin
      model[a[7:0]] = d; known[a[7:0]] = 1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1; reset = 1;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({data_oe, inputReady, ackOutput, busy, req_err} !== 5'b0 || data_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got oe/ir/ack/busy/err=%b out=%h, want 00000 out=0000",
               {data_oe, inputReady, ackOutput, busy, req_err}, data_out);
    end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_read();
    int lat; logic [W-1:0] rd; logic oe; bit q;
    xact(1, 16'h0005, 16'h1234, 0, lat, rd, oe, q);
    tests++;
    if (lat != LAT || oe !== 1'b0 || !q) begin
      fails++; $display("FAIL wr_latency: got lat=%0d oe=%b quiet=%0d want lat=%0d oe=0 quiet=1", lat, oe, q, LAT);
    end
    xact(0, 16'h0005, 16'h0000, 0, lat, rd, oe, q);
    tests++;
    if (lat != LAT || rd !== 16'h1234 || oe !== 1'b1 || !q) begin
      fails++; $display("FAIL rd_after_wr: got lat=%0d data=%h oe=%b quiet=%0d want lat=%0d data=1234 oe=1 quiet=1",
                        lat, rd, oe, q, LAT);
    end
  endtask

  task automatic test_req_err();
    int lat, pulses = 0; logic [W-1:0] rd; logic oe; bit q, busy_seen = 0;
    xact(1, 16'h0007, 16'h7777, 0, lat, rd, oe, q);
    @(posedge clk); #1;
    readM = 1; writeM = 1; address = 16'h0007; data_in = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req_err) pulses++;
      if (busy) busy_seen = 1;
      @(posedge clk);
    end
    #1; readM = 0; writeM = 0;
    @(negedge clk);
    tests++;
    if (pulses != 1 || busy_seen) begin
      fails++; $display("FAIL req_err_pulse: got pulses=%0d busy_seen=%0d want 1 and 0", pulses, busy_seen);
    end
    xact(0, 16'h0007, 16'h0000, 0, lat, rd, oe, q);
    tests++;
    if (lat != LAT || rd !== 16'h7777) begin
      fails++; $display("FAIL req_err_mem: got lat=%0d data=%h want lat=%0d data=7777", lat, rd, LAT);
    end
  endtask

  task automatic test_release_hold();
    int pulses = 0;
    @(posedge clk); #1; readM = 1; address = 16'h0005;
    @(posedge clk);
    for (int i = 0; i < LAT + 7; i++) begin
      @(negedge clk);
      if (inputReady) pulses++;
    end
    tests++;
    if (pulses != 1 || busy !== 1'b1) begin
      fails++; $display("FAIL release_hold: got pulses=%0d busy=%b want 1 and 1", pulses, busy);
    end
    readM = 0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL release_exit: got busy=%b want 0", busy); end
    readM = 1; pulses = 0;
    @(posedge clk);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (inputReady) pulses++;
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL release_rearm: got pulses=%0d want 1", pulses); end
    readM = 0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_alias();
    int lat; logic [W-1:0] rd; logic oe; bit q;
    xact(1, 16'h0103, 16'hBEEF, 0, lat, rd, oe, q);
    xact(0, 16'h0003, 16'h0000, 0, lat, rd, oe, q);
    tests++;
    if (lat != LAT || rd !== 16'hBEEF) begin
      fails++; $display("FAIL addr_alias: got lat=%0d data=%h want lat=%0d data=beef", lat, rd, LAT);
    end
  endtask

  task automatic test_reset_abort();
    int lat, acks = 0; logic [W-1:0] rd; logic oe; bit q;
    xact(1, 16'h0010, 16'h5555, 0, lat, rd, oe, q);
    @(posedge clk); #1; writeM = 1; address = 16'h0010; data_in = 16'hAAAA;
    @(posedge clk);
    @(negedge clk); reset = 1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (ackOutput) acks++;
      if (i == 0) reset = 0;
      if (i == 0) writeM = 0;
    end
    tests++;
    if (acks != 0) begin fails++; $display("FAIL reset_abort_ack: got acks=%0d want 0", acks); end
    xact(0, 16'h0010, 16'h0000, 0, lat, rd, oe, q);
    tests++;
    if (lat != LAT || rd !== 16'h5555) begin
      fails++; $display("FAIL reset_abort_mem: got lat=%0d data=%h want lat=%0d data=5555", lat, rd, LAT);
    end
    // A request held through reset is taken on the first IDLE cycle afterwards.
    @(posedge clk); #1; reset = 1; readM = 1; address = 16'h0010;
    @(posedge clk); #1; reset = 0;
    lat = -1;
    @(posedge clk);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (inputReady && lat < 0) begin lat = i; rd = data_out; end
    end
    tests++;
    if (lat != LAT || rd !== 16'h5555) begin
      fails++; $display("FAIL reset_held_req: got lat=%0d data=%h want lat=%0d data=5555", lat, rd, LAT);
    end
    readM = 0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_drop_mid();
    int lat; logic [W-1:0] rd; logic oe; bit q;
    xact(1, 16'h0020, 16'h0F0F, 0, lat, rd, oe, q);
    xact(1, 16'h0021, 16'hC0DE, 1, lat, rd, oe, q);
    tests++;
    if (lat != LAT) begin fails++; $display("FAIL drop_mid_ack: got lat=%0d want %0d", lat, LAT); end
    xact(0, 16'h0021, 16'h0000, 0, lat, rd, oe, q);
    tests++;
    if (rd !== 16'hC0DE) begin fails++; $display("FAIL drop_mid_data: got %h want c0de", rd); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] rd, a, d; logic oe; bit q, wr, dm;
    for (int i = 0; i < 40; i++) begin
      wr = bit'($urandom_range(0, 1));
      dm = ($urandom_range(0, 3) == 0);
      a = W'({$urandom_range(0, 255), 4'h0} >> 4) | W'($urandom_range(0, 3) << 8);
      a = {W'($urandom_range(0, 3)), a[7:0]} ;
      a = {a[15:8] & 8'h03, 8'(16 + $urandom_range(0, 15))};
      d = W'($urandom);
      xact(wr, a, d, dm, lat, rd, oe, q);
      tests++;
      if (lat != LAT || oe !== !wr || !q ||
          (!wr && known[a[7:0]] && rd !== model[a[7:0]])) begin
        fails++;
        $display("FAIL random[%0d]: wr=%0d addr=%h got lat=%0d oe=%b data=%h quiet=%0d want lat=%0d oe=%0d data=%h",
                 i, wr, a, lat, oe, rd, q, LAT, !wr, model[a[7:0]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_req_err();
    test_release_hold();
    test_alias();
    test_reset_abort();
    test_drop_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of words stored (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 SHALL have port readM  input  1  CPU read request, level, held until response.
REQ-007 SHALL have port writeM  input  1  CPU write request, level, held until response.
REQ-008 SHALL have port address  input  WORD_SIZE  word address from CPU.
REQ-009 SHALL have port data_in  input  WORD_SIZE  write data from CPU (CPU drive side of shared data bus).
REQ-010 SHALL have port data_out  output  WORD_SIZE  read data to CPU.
REQ-011 SHALL have port data_oe  output  1  high while data_out must drive the shared bus; bus is high-Z otherwise.
REQ-012 SHALL have port inputReady  output  1  one-cycle pulse: read data valid on data_out.
REQ-013 SHALL have port ackOutput  output  1  one-cycle pulse: write committed.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port req_err  output  1  one-cycle pulse: readM and writeM both high in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, RELEASE.
REQ-017 In IDLE, readM=1 & writeM=0 SHALL latch address and enter RD_WAIT, loading a wait counter with LATENCY-1.
REQ-018 In IDLE, writeM=1 & readM=0 SHALL latch address and data_in and enter WR_WAIT, loading the counter with LATENCY-1.
REQ-019 In IDLE, readM=1 & writeM=1 SHALL pulse req_err for one cycle, accept nothing, and remain in IDLE.
REQ-020 In RD_WAIT/WR_WAIT the counter SHALL decrement each cycle; at counter=0 the FSM SHALL move to RD_RESP/WR_RESP.
REQ-021 Acceptance at edge E0 SHALL yield inputReady/ackOutput high exactly in the cycle following edge E0+LATENCY.
REQ-022 In RD_RESP, inputReady=1, data_oe=1 and data_out=mem[latched address] for exactly one cycle, then RELEASE.
REQ-023 In WR_RESP, mem[latched address] SHALL be written with latched data and ackOutput=1 for exactly one cycle, then RELEASE.
REQ-024 Outside RD_RESP, data_oe SHALL be 0 and data_out SHALL be 0.
REQ-025 RELEASE SHALL return to IDLE on the first cycle in which readM=0 and writeM=0; no new request is accepted before that.
REQ-026 Request deassertion during RD_WAIT/WR_WAIT SHALL NOT abort the transaction; the response and write commit still occur.
REQ-027 Address and write data changes after acceptance SHALL be ignored (latched values only).
REQ-028 Memory index SHALL be address modulo DEPTH (low log2(DEPTH) bits); upper address bits are ignored, no error.
REQ-029 A read immediately after a write to the same address SHALL return the newly written value.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 With reset=1 at a rising edge, FSM SHALL enter IDLE and counter SHALL clear.
REQ-032 During and after reset: data_out=0, data_oe=0, inputReady=0, ackOutput=0, busy=0, req_err=0.
REQ-033 Reset in RD_WAIT/WR_WAIT/RESP SHALL abort the transaction; a write not yet in WR_RESP SHALL not modify memory.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 After reset release, a request held high SHALL be accepted in the first IDLE cycle.

Verification
REQ-036 LATENCY=2: write 0x1234 to 0x0005 at edge E0 -> ackOutput high only in cycle after E2; then read 0x0005 -> inputReady after E2 of read, data_out=0x1234, data_oe=1 for that cycle.
REQ-037 readM and writeM both high in IDLE -> req_err one-cycle pulse, busy=0, memory unchanged.
REQ-038 readM held high after inputReady -> FSM stays in RELEASE, no second inputReady until readM drops and rises again.
REQ-039 Write 0xBEEF to 0x0103 with DEPTH=256 -> read of 0x0003 returns 0xBEEF.
REQ-040 Reset asserted one cycle into WR_WAIT with data 0xAAAA to 0x0010 -> no ackOutput, subsequent read of 0x0010 returns prior value.
REQ-041 writeM dropped and address changed during WR_WAIT -> ackOutput still pulses, write lands at originally latched address.
